// File: rtl/apb_pkg.sv
// Shared types and address-map constants for the APB slave decoder/mux.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        TOUT   = 2'd2
    } apb_state_t;

    localparam int unsigned APB_DATA_W   = 32;
    localparam logic [15:0] APB_BASE_HI  = 16'h2000;
    localparam int unsigned APB_SLOT_LSB = 8;
    localparam int unsigned APB_IDX_W    = 4;
    localparam int unsigned UART_SLOT    = 0;

endpackage

// File: rtl/apb_wait_timer.sv
// Counts slave wait states and flags the last permitted one; TIMEOUT_CYCLES=0 never expires.
module apb_wait_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire_c
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned LAST  = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign expire_c = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(LAST));

endmodule

// File: rtl/apb_slave_mux.sv
// APB3 address decoder and response mux: one-hot slave selects, unmapped/timeout
// error responses, and a saturating count of error completions.
module apb_slave_mux
    import apb_pkg::*;
#(
    parameter int unsigned NUM_SLAVES     = 4,
    parameter int unsigned DATA_W         = APB_DATA_W,
    parameter logic [15:0] BASE_HI        = APB_BASE_HI,
    parameter int unsigned SLOT_LSB       = APB_SLOT_LSB,
    parameter int unsigned IDX_W          = APB_IDX_W,
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned ERRCNT_W       = 8
) (
    input  logic                         PCLK,
    input  logic                         PRESETn,
    input  logic [31:0]                  PADDR,
    input  logic                         PSEL,
    input  logic                         PENABLE,
    output logic [NUM_SLAVES-1:0]        PSEL_S,
    input  logic [NUM_SLAVES*DATA_W-1:0] PRDATA_S,
    input  logic [NUM_SLAVES-1:0]        PREADY_S,
    input  logic [NUM_SLAVES-1:0]        PSLVERR_S,
    output logic [DATA_W-1:0]            PRDATA,
    output logic                         PREADY,
    output logic                         PSLVERR,
    input  logic                         ERR_CLR,
    output logic [ERRCNT_W-1:0]          ERR_COUNT
);

    apb_state_t            state_q, state_d;
    logic [IDX_W-1:0]      sel_idx_q, sel_idx_d;
    logic                  mapped_q, mapped_d;
    logic [IDX_W-1:0]      addr_idx;
    logic                  addr_hit;
    logic [NUM_SLAVES-1:0] live_sel;
    logic [NUM_SLAVES-1:0] sel_onehot;
    logic [DATA_W-1:0]     sel_rdata;
    logic                  sel_ready;
    logic                  sel_err;
    logic                  tmr_clr;
    logic                  tmr_en;
    logic                  tmr_expire;
    logic [ERRCNT_W-1:0]   err_q;
    logic                  unused_addr;

    // Only the base and slot-index fields take part in decode.
    assign unused_addr = ^PADDR;

    // Live address decode plus the response mux for the latched slot.
    always_comb begin
        addr_idx   = PADDR[SLOT_LSB +: IDX_W];
        addr_hit   = (PADDR[31:16] == BASE_HI) &&
                     ({1'b0, addr_idx} < (IDX_W + 1)'(NUM_SLAVES));
        live_sel   = '0;
        sel_onehot = '0;
        sel_rdata  = '0;
        sel_ready  = 1'b0;
        sel_err    = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            live_sel[i]   = PSEL && addr_hit && (addr_idx == IDX_W'(i));
            sel_onehot[i] = (sel_idx_q == IDX_W'(i));
            if (sel_idx_q == IDX_W'(i)) begin
                sel_rdata = PRDATA_S[i*DATA_W +: DATA_W];
                sel_ready = PREADY_S[i];
                sel_err   = PSLVERR_S[i];
            end
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q   <= IDLE;
            sel_idx_q <= '0;
            mapped_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_idx_q <= sel_idx_d;
            mapped_q  <= mapped_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sel_idx_d = sel_idx_q;
        mapped_d  = mapped_q;
        tmr_clr   = 1'b0;
        tmr_en    = 1'b0;
        PSEL_S    = '0;
        PRDATA    = '0;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;

        case (state_q)
            IDLE: begin
                PSEL_S = live_sel;
                if (PSEL && !PENABLE) begin
                    sel_idx_d = addr_idx;
                    mapped_d  = addr_hit;
                    tmr_clr   = 1'b1;
                    state_d   = ACCESS;
                end
            end
            ACCESS: begin
                // Bridge dropped PSEL mid-transfer: abandon silently.
                if (!PSEL) begin
                    state_d = IDLE;
                end else if (mapped_q) begin
                    PSEL_S  = sel_onehot;
                    PRDATA  = sel_rdata;
                    PREADY  = sel_ready;
                    PSLVERR = sel_err & sel_ready;
                    if (sel_ready) begin
                        state_d = IDLE;
                    end else if (tmr_expire) begin
                        state_d = TOUT;
                    end else begin
                        tmr_en = 1'b1;
                    end
                end else begin
                    PREADY  = 1'b1;
                    PSLVERR = 1'b1;
                    state_d = IDLE;
                end
            end
            TOUT: begin
                PREADY  = 1'b1;
                PSLVERR = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Outputs fall to zero as soon as reset asserts, independent of the clock.
        if (!PRESETn) begin
            PSEL_S  = '0;
            PRDATA  = '0;
            PREADY  = 1'b0;
            PSLVERR = 1'b0;
        end
    end

    apb_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk     (PCLK),
        .rst_n   (PRESETn),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .expire_c(tmr_expire)
    );

    // Saturating error-completion counter; clear wins over a same-cycle increment.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            err_q <= '0;
        end else if (ERR_CLR) begin
            err_q <= '0;
        end else if (PREADY && PSLVERR && (err_q != '1)) begin
            err_q <= err_q + ERRCNT_W'(1);
        end
    end

    assign ERR_COUNT = err_q;

endmodule

// File: tb/tb_apb_slave_mux.sv
// Scoreboard bench for apb_slave_mux: transfers push expected responses, a monitor pops them.
module tb_apb_slave_mux;

    typedef struct {
        logic [3:0]  setup_sel;
        logic [3:0]  done_sel;
        logic [31:0] rdata;
        logic        slverr;
        int          waits;
    } exp_t;

    logic         PCLK;
    logic         PRESETn;
    logic [31:0]  PADDR;
    logic         PSEL;
    logic         PENABLE;
    logic [3:0]   PSEL_S;
    logic [127:0] PRDATA_S;
    logic [3:0]   PREADY_S;
    logic [3:0]   PSLVERR_S;
    logic [31:0]  PRDATA;
    logic         PREADY;
    logic         PSLVERR;
    logic         ERR_CLR;
    logic [7:0]   ERR_COUNT;

    logic [3:0]   psel_s2;
    logic [31:0]  prdata2;
    logic         pready2;
    logic         pslverr2;
    logic [1:0]   err_count2;

    logic [31:0]  sdata [4];
    exp_t         exp_q [$];
    logic [7:0]   exp_err;
    logic [1:0]   exp_err2;
    int           checks;
    int           errors;
    int           acc_cnt;

    assign PRDATA_S = {sdata[3], sdata[2], sdata[1], sdata[0]};

    apb_slave_mux u_dut (
        .PCLK     (PCLK),
        .PRESETn  (PRESETn),
        .PADDR    (PADDR),
        .PSEL     (PSEL),
        .PENABLE  (PENABLE),
        .PSEL_S   (PSEL_S),
        .PRDATA_S (PRDATA_S),
        .PREADY_S (PREADY_S),
        .PSLVERR_S(PSLVERR_S),
        .PRDATA   (PRDATA),
        .PREADY   (PREADY),
        .PSLVERR  (PSLVERR),
        .ERR_CLR  (ERR_CLR),
        .ERR_COUNT(ERR_COUNT)
    );

    apb_slave_mux #(.ERRCNT_W(2)) u_dut2 (
        .PCLK     (PCLK),
        .PRESETn  (PRESETn),
        .PADDR    (PADDR),
        .PSEL     (PSEL),
        .PENABLE  (PENABLE),
        .PSEL_S   (psel_s2),
        .PRDATA_S (PRDATA_S),
        .PREADY_S (PREADY_S),
        .PSLVERR_S(PSLVERR_S),
        .PRDATA   (prdata2),
        .PREADY   (pready2),
        .PSLVERR  (pslverr2),
        .ERR_CLR  (ERR_CLR),
        .ERR_COUNT(err_count2)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    // Monitor: checks selects in setup/wait cycles and pops one expectation per completion.
    always @(negedge PCLK) begin
        exp_t e;
        if (!PRESETn || !PSEL) begin
            acc_cnt = 0;
        end else if (!PENABLE) begin
            acc_cnt = 0;
            if (exp_q.size() != 0) begin
                checks++;
                if (PSEL_S !== exp_q[0].setup_sel) begin
                    errors++;
                    $display("FAIL setup_sel: got %b expected %b", PSEL_S, exp_q[0].setup_sel);
                end
            end
        end else if (exp_q.size() != 0) begin
            if (PREADY === 1'b1) begin
                e = exp_q.pop_front();
                checks++;
                if (PRDATA !== e.rdata) begin
                    errors++;
                    $display("FAIL rdata: got %h expected %h", PRDATA, e.rdata);
                end
                checks++;
                if (PSLVERR !== e.slverr) begin
                    errors++;
                    $display("FAIL slverr: got %b expected %b", PSLVERR, e.slverr);
                end
                checks++;
                if (PSEL_S !== e.done_sel) begin
                    errors++;
                    $display("FAIL done_sel: got %b expected %b", PSEL_S, e.done_sel);
                end
                checks++;
                if (acc_cnt != e.waits) begin
                    errors++;
                    $display("FAIL wait_states: got %0d expected %0d", acc_cnt, e.waits);
                end
                acc_cnt = 0;
            end else begin
                checks++;
                if (PSEL_S !== exp_q[0].setup_sel || PSLVERR !== 1'b0) begin
                    errors++;
                    $display("FAIL wait_cycle: sel %b slverr %b expected sel %b slverr 0",
                             PSEL_S, PSLVERR, exp_q[0].setup_sel);
                end
                acc_cnt++;
            end
        end
    end

    // One APB transfer; waits < 0 means the slave never becomes ready.
    task automatic xfer(input logic [31:0] addr, input int waits, input logic serr,
                        input logic clr);
        exp_t       e;
        logic [3:0] sel;
        logic       hit;
        int         slot;
        int         n;
        hit  = (addr[31:16] == 16'h2000) && (addr[11:8] < 4'd4);
        slot = int'(addr[9:8]);
        sel  = hit ? (4'b0001 << slot) : 4'b0000;
        if (!hit)
            e = '{4'b0000, 4'b0000, 32'h0, 1'b1, 0};
        else if (waits >= 0 && waits < 16)
            e = '{sel, sel, sdata[slot], serr, waits};
        else
            e = '{sel, 4'b0000, 32'h0, 1'b1, 16};
        exp_q.push_back(e);
        if (clr) begin
            exp_err  = 8'd0;
            exp_err2 = 2'd0;
        end else if (e.slverr) begin
            if (exp_err != 8'hFF) exp_err = exp_err + 8'd1;
            if (exp_err2 != 2'd3) exp_err2 = exp_err2 + 2'd1;
        end

        PADDR     = addr;
        PSEL      = 1'b1;
        PENABLE   = 1'b0;
        PREADY_S  = '0;
        PSLVERR_S = '0;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        ERR_CLR = clr;
        if (hit) begin
            PSLVERR_S[slot] = serr;
            PREADY_S[slot]  = (waits == 0);
        end
        n = 0;
        forever begin
            @(negedge PCLK);
            if (PREADY === 1'b1) break;
            if (n >= 40) begin
                checks++;
                errors++;
                $display("FAIL xfer_timeout: addr %h no PREADY after %0d cycles", addr, n);
                break;
            end
            @(posedge PCLK); #1;
            n++;
            if (hit) PREADY_S[slot] = (n == waits);
        end
        @(posedge PCLK); #1;
        PSEL      = 1'b0;
        PENABLE   = 1'b0;
        PREADY_S  = '0;
        PSLVERR_S = '0;
        ERR_CLR   = 1'b0;
    endtask

    task automatic test_reset();
        PRESETn = 1'b0;
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        PADDR   = 32'h2000_0100;
        #3;
        checks++;
        if (PSEL_S !== 4'b0000 || PREADY !== 1'b0 || PSLVERR !== 1'b0 || PRDATA !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: sel %b ready %b err %b rdata %h expected all zero",
                     PSEL_S, PREADY, PSLVERR, PRDATA);
        end
        checks++;
        if (ERR_COUNT !== 8'd0 || err_count2 !== 2'd0) begin
            errors++;
            $display("FAIL reset_errcnt: got %0d/%0d expected 0/0", ERR_COUNT, err_count2);
        end
        repeat (2) @(posedge PCLK);
        #1;
        PSEL    = 1'b0;
        PRESETn = 1'b1;
        @(posedge PCLK); #1;
        checks++;
        if (PSEL_S !== 4'b0000) begin
            errors++;
            $display("FAIL idle_sel: got %b expected 0000", PSEL_S);
        end
    endtask

    task automatic test_read_slot0();
        xfer(32'h2000_0000, 0, 1'b0, 1'b0);
        checks++;
        if (ERR_COUNT !== exp_err) begin
            errors++;
            $display("FAIL read_slot0_errcnt: got %0d expected %0d", ERR_COUNT, exp_err);
        end
    endtask

    task automatic test_wait_states();
        xfer(32'h2000_0300, 5, 1'b0, 1'b0);
        xfer(32'h2000_0100, 2, 1'b1, 1'b0);
        checks++;
        if (ERR_COUNT !== exp_err) begin
            errors++;
            $display("FAIL slave_err_errcnt: got %0d expected %0d", ERR_COUNT, exp_err);
        end
    endtask

    task automatic test_unmapped();
        xfer(32'h2000_0500, 0, 1'b0, 1'b0);
        checks++;
        if (ERR_COUNT !== exp_err) begin
            errors++;
            $display("FAIL unmapped_idx_errcnt: got %0d expected %0d", ERR_COUNT, exp_err);
        end
        xfer(32'h3000_0000, 0, 1'b0, 1'b0);
        checks++;
        if (ERR_COUNT !== exp_err) begin
            errors++;
            $display("FAIL unmapped_base_errcnt: got %0d expected %0d", ERR_COUNT, exp_err);
        end
    endtask

    task automatic test_timeout();
        xfer(32'h2000_0100, -1, 1'b0, 1'b0);
        xfer(32'h2000_0000, 0, 1'b0, 1'b0);
        checks++;
        if (ERR_COUNT !== exp_err) begin
            errors++;
            $display("FAIL timeout_errcnt: got %0d expected %0d", ERR_COUNT, exp_err);
        end
    endtask

    task automatic test_back_to_back();
        xfer(32'h2000_0200, 1, 1'b0, 1'b0);
        xfer(32'h2000_0000, 0, 1'b0, 1'b0);
        xfer(32'h2000_0700, 0, 1'b0, 1'b0);
        xfer(32'h2000_0300, 3, 1'b1, 1'b0);
        checks++;
        if (ERR_COUNT !== exp_err) begin
            errors++;
            $display("FAIL b2b_errcnt: got %0d expected %0d", ERR_COUNT, exp_err);
        end
    endtask

    task automatic test_abort();
        PADDR    = 32'h2000_0200;
        PSEL     = 1'b1;
        PENABLE  = 1'b0;
        PREADY_S = '0;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        @(negedge PCLK);
        checks++;
        if (PREADY !== 1'b0 || PSLVERR !== 1'b0 || PSEL_S !== 4'b0000) begin
            errors++;
            $display("FAIL abort_response: ready %b err %b sel %b expected 0 0 0000",
                     PREADY, PSLVERR, PSEL_S);
        end
        @(posedge PCLK); #1;
        checks++;
        if (ERR_COUNT !== exp_err) begin
            errors++;
            $display("FAIL abort_errcnt: got %0d expected %0d", ERR_COUNT, exp_err);
        end
        xfer(32'h2000_0200, 0, 1'b0, 1'b0);
    endtask

    task automatic test_err_sat();
        ERR_CLR = 1'b1;
        @(posedge PCLK); #1;
        ERR_CLR  = 1'b0;
        exp_err  = 8'd0;
        exp_err2 = 2'd0;
        checks++;
        if (ERR_COUNT !== 8'd0 || err_count2 !== 2'd0) begin
            errors++;
            $display("FAIL err_clr: got %0d/%0d expected 0/0", ERR_COUNT, err_count2);
        end
        for (int k = 0; k < 5; k++) begin
            xfer(32'h3000_0000, 0, 1'b0, 1'b0);
            checks++;
            if (err_count2 !== exp_err2) begin
                errors++;
                $display("FAIL err_sat_%0d: got %0d expected %0d", k, err_count2, exp_err2);
            end
        end
        checks++;
        if (ERR_COUNT !== exp_err) begin
            errors++;
            $display("FAIL err_wide: got %0d expected %0d", ERR_COUNT, exp_err);
        end
        xfer(32'h2000_0F00, 0, 1'b0, 1'b1);
        checks++;
        if (ERR_COUNT !== 8'd0 || err_count2 !== 2'd0) begin
            errors++;
            $display("FAIL clr_priority: got %0d/%0d expected 0/0", ERR_COUNT, err_count2);
        end
    endtask

    task automatic test_reset_mid();
        xfer(32'h3000_0000, 0, 1'b0, 1'b0);
        checks++;
        if (ERR_COUNT !== exp_err) begin
            errors++;
            $display("FAIL pre_reset_errcnt: got %0d expected %0d", ERR_COUNT, exp_err);
        end
        PADDR    = 32'h2000_0200;
        PSEL     = 1'b1;
        PENABLE  = 1'b0;
        PREADY_S = '0;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        repeat (3) begin
            @(posedge PCLK); #1;
        end
        @(negedge PCLK);
        checks++;
        if (PSEL_S !== 4'b0100 || PREADY !== 1'b0) begin
            errors++;
            $display("FAIL mid_wait: sel %b ready %b expected 0100 0", PSEL_S, PREADY);
        end
        #2;
        PRESETn = 1'b0;
        #1;
        exp_err  = 8'd0;
        exp_err2 = 2'd0;
        checks++;
        if (PSEL_S !== 4'b0000 || PREADY !== 1'b0 || PSLVERR !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: sel %b ready %b err %b expected 0000 0 0",
                     PSEL_S, PREADY, PSLVERR);
        end
        checks++;
        if (ERR_COUNT !== exp_err) begin
            errors++;
            $display("FAIL reset_errcnt_mid: got %0d expected %0d", ERR_COUNT, exp_err);
        end
        @(posedge PCLK); #1;
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        @(posedge PCLK); #1;
        PRESETn = 1'b1;
        @(posedge PCLK); #1;
        xfer(32'h2000_0200, 2, 1'b0, 1'b0);
        checks++;
        if (ERR_COUNT !== exp_err) begin
            errors++;
            $display("FAIL post_reset_errcnt: got %0d expected %0d", ERR_COUNT, exp_err);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        acc_cnt   = 0;
        exp_err   = 8'd0;
        exp_err2  = 2'd0;
        sdata[0]  = 32'hA5A5_0001;
        sdata[1]  = 32'h1111_2222;
        sdata[2]  = 32'hC0DE_0002;
        sdata[3]  = 32'h3333_0003;
        PRESETn   = 1'b0;
        PADDR     = '0;
        PSEL      = 1'b0;
        PENABLE   = 1'b0;
        PREADY_S  = '0;
        PSLVERR_S = '0;
        ERR_CLR   = 1'b0;

        test_reset();
        test_read_slot0();
        test_wait_states();
        test_unmapped();
        test_timeout();
        test_back_to_back();
        test_abort();
        test_err_sat();
        test_reset_mid();

        repeat (2) @(posedge PCLK);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d responses outstanding, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
